// File: rtl/mms_tlb.sv
`default_nettype none
// ============================================================================
//  Module      : mms_tlb
//  Description : Fully associative Sv32 TLB with ASID/global tagging,
//                4 MiB superpages, permission checks, selective flush and
//                first-invalid-then-round-robin refill placement.
//  Revision    : 1.0 - initial release
// ============================================================================
module mms_tlb #(
    parameter int ENTRIES = 8,
    parameter int ASID_WD = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lkp_valid_i,
    input  logic [31:0]        lkp_vaddr_i,
    input  logic [ASID_WD-1:0] lkp_asid_i,
    input  logic [1:0]         lkp_acc_i,
    input  logic               lkp_priv_i,
    input  logic               sum_i,
    output logic               resp_valid_o,
    output logic               resp_hit_o,
    output logic               resp_fault_o,
    output logic [33:0]        resp_paddr_o,
    input  logic               refill_valid_i,
    input  logic [19:0]        refill_vpn_i,
    input  logic [ASID_WD-1:0] refill_asid_i,
    input  logic [31:0]        refill_pte_i,
    input  logic               refill_super_i,
    input  logic               flush_valid_i,
    input  logic               flush_vpn_en_i,
    input  logic [19:0]        flush_vpn_i,
    input  logic               flush_asid_en_i,
    input  logic [ASID_WD-1:0] flush_asid_i,
    output logic [31:0]        miss_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Translation payload; the valid bits live separately so only they need reset.
    typedef struct packed {
        logic               super_pg;
        logic [19:0]        vpn;
        logic [ASID_WD-1:0] asid;
        logic [11:0]        ppn1;
        logic [9:0]         ppn0;
        logic               d;
        logic               a;
        logic               g;
        logic               u;
        logic               x;
        logic               w;
        logic               r;
    } entry_t;

    logic [ENTRIES-1:0] valid_q;
    entry_t             ent_q [ENTRIES];
    logic [IDX_W-1:0]   rr_q;

    logic [ENTRIES-1:0] lkp_match;
    entry_t             hit_ent;
    logic               lkp_hit;
    logic               lkp_fault;
    logic [33:0]        lkp_paddr;

    logic [ENTRIES-1:0] post_valid;
    logic               rf_ok;
    logic               rf_hit;
    logic [IDX_W-1:0]   rf_hit_idx;
    logic               rf_free;
    logic [IDX_W-1:0]   rf_free_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic               use_rr;
    entry_t             new_ent;

    logic               is_fetch;
    logic               is_load;
    logic               is_store;

    // RSW bits carry no meaning for translation.
    logic               unused_rsw;
    assign unused_rsw = ^refill_pte_i[9:8];

    assign is_fetch = (lkp_acc_i == 2'b00);
    assign is_load  = (lkp_acc_i == 2'b01);
    assign is_store = lkp_acc_i[1];

    // Associative match and selection of the (single) matching entry.
    always_comb begin
        lkp_match = '0;
        hit_ent   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            lkp_match[i] = valid_q[i]
                        && ((ent_q[i].asid == lkp_asid_i) || ent_q[i].g)
                        && (ent_q[i].vpn[19:10] == lkp_vaddr_i[31:22])
                        && ((ent_q[i].vpn[9:0] == lkp_vaddr_i[21:12]) || ent_q[i].super_pg);
            if (lkp_match[i]) begin
                hit_ent = ent_q[i];
            end
        end
    end

    // Hit qualification, permission check and physical address formation.
    always_comb begin
        lkp_hit   = (|lkp_match) && !flush_valid_i;
        lkp_fault = (is_fetch && !hit_ent.x)
                 || (is_load  && !hit_ent.r)
                 || (is_store && !hit_ent.w)
                 || !hit_ent.a
                 || (is_store && !hit_ent.d)
                 || (!lkp_priv_i && !hit_ent.u)
                 || (lkp_priv_i && is_fetch && hit_ent.u)
                 || (lkp_priv_i && !is_fetch && hit_ent.u && !sum_i)
                 || (hit_ent.super_pg && (hit_ent.ppn0 != 10'd0));
        lkp_paddr = {hit_ent.ppn1,
                     hit_ent.super_pg ? lkp_vaddr_i[21:12] : hit_ent.ppn0,
                     lkp_vaddr_i[11:0]};
    end

    // Flush first, then pick the refill slot against the post-flush state.
    always_comb begin
        post_valid  = valid_q;
        rf_ok       = refill_valid_i && refill_pte_i[0] && !(refill_pte_i[2] && !refill_pte_i[1]);
        rf_hit      = 1'b0;
        rf_hit_idx  = '0;
        rf_free     = 1'b0;
        rf_free_idx = '0;
        use_rr      = 1'b0;
        wr_idx      = rr_q;
        for (int i = 0; i < ENTRIES; i++) begin
            if (flush_valid_i
                && (!flush_vpn_en_i
                    || (ent_q[i].super_pg ? (ent_q[i].vpn[19:10] == flush_vpn_i[19:10])
                                          : (ent_q[i].vpn == flush_vpn_i)))
                && (!flush_asid_en_i
                    || ((ent_q[i].asid == flush_asid_i) && !ent_q[i].g))) begin
                post_valid[i] = 1'b0;
            end
        end
        // Descending scan so the lowest index wins.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (post_valid[i]
                && (ent_q[i].vpn[19:10] == refill_vpn_i[19:10])
                && ((ent_q[i].vpn[9:0] == refill_vpn_i[9:0]) || ent_q[i].super_pg || refill_super_i)
                && ((ent_q[i].asid == refill_asid_i) || ent_q[i].g || refill_pte_i[5])) begin
                rf_hit     = 1'b1;
                rf_hit_idx = IDX_W'(i);
            end
            if (!post_valid[i]) begin
                rf_free     = 1'b1;
                rf_free_idx = IDX_W'(i);
            end
        end
        if (rf_hit) begin
            wr_idx = rf_hit_idx;
        end else if (rf_free) begin
            wr_idx = rf_free_idx;
        end else begin
            use_rr = 1'b1;
        end
    end

    assign new_ent = '{super_pg: refill_super_i,
                       vpn:      refill_vpn_i,
                       asid:     refill_asid_i,
                       ppn1:     refill_pte_i[31:20],
                       ppn0:     refill_pte_i[19:10],
                       d:        refill_pte_i[7],
                       a:        refill_pte_i[6],
                       g:        refill_pte_i[5],
                       u:        refill_pte_i[4],
                       x:        refill_pte_i[3],
                       w:        refill_pte_i[2],
                       r:        refill_pte_i[1]};

    // Valid bits and replacement pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rr_q    <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= post_valid[i] || (rf_ok && (wr_idx == IDX_W'(i)));
            end
            if (rf_ok && use_rr) begin
                rr_q <= rr_q + IDX_W'(1);
            end
        end
    end

    // Entry payload storage, written only on an accepted refill.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (rf_ok && (wr_idx == IDX_W'(i))) begin
                ent_q[i] <= new_ent;
            end
        end
    end

    // Registered response; data fields hold when no lookup is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_o <= 1'b0;
            resp_hit_o   <= 1'b0;
            resp_fault_o <= 1'b0;
            resp_paddr_o <= '0;
        end else begin
            resp_valid_o <= lkp_valid_i;
            if (lkp_valid_i) begin
                resp_hit_o   <= lkp_hit;
                resp_fault_o <= lkp_hit && lkp_fault;
                resp_paddr_o <= lkp_hit ? lkp_paddr : 34'd0;
            end
        end
    end

    // Saturating miss counter, updated alongside the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt_o <= '0;
        end else if (lkp_valid_i && !lkp_hit && (miss_cnt_o != 32'hFFFF_FFFF)) begin
            miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mms_tlb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mms_tlb
//  Description : Self-checking bench for mms_tlb; directed scenarios followed
//                by random traffic against a behavioural TLB model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mms_tlb;

    localparam int ENTRIES = 8;
    localparam int ASID_WD = 9;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               lkp_valid = 1'b0;
    logic [31:0]        lkp_vaddr = '0;
    logic [ASID_WD-1:0] lkp_asid = '0;
    logic [1:0]         lkp_acc = '0;
    logic               lkp_priv = 1'b0;
    logic               sum = 1'b0;
    logic               resp_valid;
    logic               resp_hit;
    logic               resp_fault;
    logic [33:0]        resp_paddr;
    logic               refill_valid = 1'b0;
    logic [19:0]        refill_vpn = '0;
    logic [ASID_WD-1:0] refill_asid = '0;
    logic [31:0]        refill_pte = '0;
    logic               refill_super = 1'b0;
    logic               flush_valid = 1'b0;
    logic               flush_vpn_en = 1'b0;
    logic [19:0]        flush_vpn = '0;
    logic               flush_asid_en = 1'b0;
    logic [ASID_WD-1:0] flush_asid = '0;
    logic [31:0]        miss_cnt;

    mms_tlb #(.ENTRIES(ENTRIES), .ASID_WD(ASID_WD)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lkp_valid_i     (lkp_valid),
        .lkp_vaddr_i     (lkp_vaddr),
        .lkp_asid_i      (lkp_asid),
        .lkp_acc_i       (lkp_acc),
        .lkp_priv_i      (lkp_priv),
        .sum_i           (sum),
        .resp_valid_o    (resp_valid),
        .resp_hit_o      (resp_hit),
        .resp_fault_o    (resp_fault),
        .resp_paddr_o    (resp_paddr),
        .refill_valid_i  (refill_valid),
        .refill_vpn_i    (refill_vpn),
        .refill_asid_i   (refill_asid),
        .refill_pte_i    (refill_pte),
        .refill_super_i  (refill_super),
        .flush_valid_i   (flush_valid),
        .flush_vpn_en_i  (flush_vpn_en),
        .flush_vpn_i     (flush_vpn),
        .flush_asid_en_i (flush_asid_en),
        .flush_asid_i    (flush_asid),
        .miss_cnt_o      (miss_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: one record per slot, as the replacement rules describe.
    logic               m_valid [ENTRIES];
    logic [19:0]        m_vpn   [ENTRIES];
    logic [ASID_WD-1:0] m_asid  [ENTRIES];
    logic               m_super [ENTRIES];
    logic [31:0]        m_pte   [ENTRIES];
    int                 m_rr;
    logic [31:0]        m_miss;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_rr   = 0;
        m_miss = 32'd0;
    endtask

    // Translate using the current model contents.
    task automatic model_lookup(output logic hit, output logic fault, output logic [33:0] pa);
        logic [31:0] pte;
        logic        sp;
        logic        f;
        hit = 1'b0; fault = 1'b0; pa = '0; pte = '0; sp = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (m_valid[i] && (m_asid[i] == lkp_asid || m_pte[i][5])
                && m_vpn[i][19:10] == lkp_vaddr[31:22]
                && (m_vpn[i][9:0] == lkp_vaddr[21:12] || m_super[i])) begin
                hit = 1'b1; pte = m_pte[i]; sp = m_super[i];
            end
        end
        if (hit) begin
            // pte bits: 7 D, 6 A, 5 G, 4 U, 3 X, 2 W, 1 R
            f = 1'b0;
            if (lkp_acc == 2'b00 && !pte[3]) f = 1'b1;
            if (lkp_acc == 2'b01 && !pte[1]) f = 1'b1;
            if (lkp_acc >= 2'b10 && !pte[2]) f = 1'b1;
            if (!pte[6]) f = 1'b1;
            if (lkp_acc >= 2'b10 && !pte[7]) f = 1'b1;
            if (!lkp_priv && !pte[4]) f = 1'b1;
            if (lkp_priv && lkp_acc == 2'b00 && pte[4]) f = 1'b1;
            if (lkp_priv && lkp_acc != 2'b00 && pte[4] && !sum) f = 1'b1;
            if (sp && pte[19:10] != 10'd0) f = 1'b1;
            fault = f;
            if (sp) pa = {pte[31:20], 22'd0} + {12'd0, lkp_vaddr[21:0]};
            else    pa = {pte[31:10], 12'd0} + {22'd0, lkp_vaddr[11:0]};
        end
    endtask

    task automatic model_flush();
        logic sel;
        for (int i = 0; i < ENTRIES; i++) begin
            sel = 1'b1;
            if (flush_vpn_en)
                sel = m_super[i] ? (m_vpn[i][19:10] == flush_vpn[19:10]) : (m_vpn[i] == flush_vpn);
            if (flush_asid_en && !(m_asid[i] == flush_asid && !m_pte[i][5])) sel = 1'b0;
            if (sel) m_valid[i] = 1'b0;
        end
    endtask

    task automatic model_refill();
        int idx;
        if (!refill_pte[0] || (refill_pte[2] && !refill_pte[1])) return;
        idx = -1;
        for (int i = 0; i < ENTRIES; i++) begin
            if (idx < 0 && m_valid[i] && m_vpn[i][19:10] == refill_vpn[19:10]
                && (m_vpn[i][9:0] == refill_vpn[9:0] || m_super[i] || refill_super)
                && (m_asid[i] == refill_asid || m_pte[i][5] || refill_pte[5]))
                idx = i;
        end
        for (int i = 0; i < ENTRIES; i++) if (idx < 0 && !m_valid[i]) idx = i;
        if (idx < 0) begin
            idx  = m_rr;
            m_rr = (m_rr + 1) % ENTRIES;
        end
        m_valid[idx] = 1'b1;
        m_vpn[idx]   = refill_vpn;
        m_asid[idx]  = refill_asid;
        m_super[idx] = refill_super;
        m_pte[idx]   = refill_pte;
    endtask

    // One clock with the currently driven inputs; checks the resulting response.
    task automatic step();
        logic        e_lv, e_hit, e_fault;
        logic [33:0] e_pa;
        e_lv = lkp_valid;
        model_lookup(e_hit, e_fault, e_pa);
        if (flush_valid) e_hit = 1'b0;
        @(posedge clk);
        if (flush_valid)  model_flush();
        if (refill_valid) model_refill();
        if (e_lv && !e_hit && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
        #1;
        check("resp_valid", {63'd0, resp_valid}, {63'd0, e_lv});
        if (e_lv) begin
            check("resp_hit", {63'd0, resp_hit}, {63'd0, e_hit});
            if (e_hit) begin
                check("resp_fault", {63'd0, resp_fault}, {63'd0, e_fault});
                check("resp_paddr", {30'd0, resp_paddr}, {30'd0, e_pa});
            end
        end
        check("miss_cnt", {32'd0, miss_cnt}, {32'd0, m_miss});
        lkp_valid = 1'b0; refill_valid = 1'b0; flush_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic lookup(input logic [31:0] va, input logic [ASID_WD-1:0] asid,
                          input logic [1:0] acc, input logic priv, input logic s);
        lkp_valid = 1'b1; lkp_vaddr = va; lkp_asid = asid;
        lkp_acc = acc; lkp_priv = priv; sum = s;
        step();
    endtask

    task automatic set_refill(input logic [19:0] vpn, input logic [ASID_WD-1:0] asid,
                              input logic [31:0] pte, input logic sp);
        refill_valid = 1'b1; refill_vpn = vpn; refill_asid = asid;
        refill_pte = pte; refill_super = sp;
    endtask

    task automatic refill(input logic [19:0] vpn, input logic [ASID_WD-1:0] asid,
                          input logic [31:0] pte, input logic sp);
        set_refill(vpn, asid, pte, sp);
        step();
    endtask

    task automatic set_flush(input logic ve, input logic [19:0] v,
                             input logic ae, input logic [ASID_WD-1:0] a);
        flush_valid = 1'b1; flush_vpn_en = ve; flush_vpn = v;
        flush_asid_en = ae; flush_asid = a;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_hit",   {63'd0, resp_hit},   64'd0);
        check("rst_fault", {63'd0, resp_fault}, 64'd0);
        check("rst_paddr", {30'd0, resp_paddr}, 64'd0);
        check("rst_miss",  {32'd0, miss_cnt},   64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // First lookup after reset misses.
        lookup(32'h1234_5678, 9'd1, 2'b01, 1'b1, 1'b0);
        check("first_miss_hit", {63'd0, resp_hit}, 64'd0);
        check("first_miss_cnt", {32'd0, miss_cnt}, 64'd1);

        // Basic 4 KiB translation and ASID separation.
        refill(20'h12345, 9'd1, {22'h00ABC, 2'b00, 8'hC7}, 1'b0);
        lookup(32'h1234_5678, 9'd1, 2'b01, 1'b1, 1'b0);
        check("load_hit",   {63'd0, resp_hit},   64'd1);
        check("load_paddr", {30'd0, resp_paddr}, 64'h00ABC678);
        lookup(32'h1234_5678, 9'd2, 2'b01, 1'b1, 1'b0);
        check("asid2_miss", {63'd0, resp_hit}, 64'd0);

        // Global superpage, then misaligned superpage overwrite.
        refill({10'h048, 10'h000}, 9'd5, {12'h123, 10'h000, 2'b00, 8'hEB}, 1'b1);
        lookup(32'h1230_0ABC, 9'd7, 2'b00, 1'b1, 1'b0);
        check("super_paddr", {30'd0, resp_paddr}, 64'h48F00ABC);
        check("super_fault", {63'd0, resp_fault}, 64'd0);
        refill({10'h048, 10'h000}, 9'd5, {12'h123, 10'h001, 2'b00, 8'hEB}, 1'b1);
        lookup(32'h1230_0ABC, 9'd3, 2'b00, 1'b1, 1'b0);
        check("super_misalign", {63'd0, resp_fault}, 64'd1);

        // Permission cases.
        refill(20'h00010, 9'd1, {22'h00111, 2'b00, 8'h4F}, 1'b0);
        lookup(32'h0001_0010, 9'd1, 2'b10, 1'b1, 1'b0);
        check("store_d0", {63'd0, resp_fault}, 64'd1);
        lookup(32'h1234_5000, 9'd1, 2'b01, 1'b0, 1'b0);
        check("umode_u0", {63'd0, resp_fault}, 64'd1);
        refill(20'h00011, 9'd1, {22'h00222, 2'b00, 8'hD7}, 1'b0);
        lookup(32'h0001_1004, 9'd1, 2'b01, 1'b1, 1'b0);
        check("smode_u1_sum0", {63'd0, resp_fault}, 64'd1);
        lookup(32'h0001_1004, 9'd1, 2'b01, 1'b1, 1'b1);
        check("smode_u1_sum1", {63'd0, resp_fault}, 64'd0);

        // Capacity: ENTRIES+2 fills evict slots 0 and 1.
        set_flush(1'b0, '0, 1'b0, '0);
        step();
        for (int k = 0; k < ENTRIES + 2; k++)
            refill(20'h20000 + 20'(k), 9'd3, {22'(k + 16), 2'b00, 8'hCF}, 1'b0);
        for (int k = 0; k < ENTRIES + 2; k++) begin
            lookup({20'h20000 + 20'(k), 12'h010}, 9'd3, 2'b01, 1'b1, 1'b0);
            check("evict_hit", {63'd0, resp_hit}, {63'd0, (k >= 2)});
        end

        // ASID-only flush keeps global and other-ASID entries.
        set_flush(1'b0, '0, 1'b0, '0);
        step();
        refill(20'h30001, 9'd1, {22'h00301, 2'b00, 8'hCF}, 1'b0);
        refill(20'h30002, 9'd2, {22'h00302, 2'b00, 8'hCF}, 1'b0);
        refill(20'h30003, 9'd1, {22'h00303, 2'b00, 8'hEF}, 1'b0);
        set_flush(1'b0, '0, 1'b1, 9'd1);
        lkp_valid = 1'b1; lkp_vaddr = 32'h3000_2000; lkp_asid = 9'd2;
        step();
        check("lkp_during_flush", {63'd0, resp_hit}, 64'd0);
        lookup(32'h3000_1000, 9'd1, 2'b01, 1'b1, 1'b0);
        check("asid_flushed", {63'd0, resp_hit}, 64'd0);
        lookup(32'h3000_2000, 9'd2, 2'b01, 1'b1, 1'b0);
        check("asid2_kept", {63'd0, resp_hit}, 64'd1);
        lookup(32'h3000_3000, 9'd1, 2'b01, 1'b1, 1'b0);
        check("global_kept", {63'd0, resp_hit}, 64'd1);

        // Refill with simultaneous full flush survives.
        set_flush(1'b0, '0, 1'b0, '0);
        set_refill(20'h30004, 9'd1, {22'h00304, 2'b00, 8'hCF}, 1'b0);
        step();
        lookup(32'h3000_4000, 9'd1, 2'b01, 1'b1, 1'b0);
        check("refill_survives", {63'd0, resp_hit}, 64'd1);
        lookup(32'h3000_3000, 9'd1, 2'b01, 1'b1, 1'b0);
        check("others_flushed", {63'd0, resp_hit}, 64'd0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                lkp_valid = 1'b1;
                lkp_vaddr = {10'($urandom_range(1, 3)), 10'($urandom_range(0, 3)), 12'($urandom)};
                lkp_asid  = 9'($urandom_range(0, 3));
                lkp_acc   = 2'($urandom);
                lkp_priv  = 1'($urandom);
                sum       = 1'($urandom);
            end
            if ($urandom_range(0, 2) == 0)
                set_refill({10'($urandom_range(1, 3)), 10'($urandom_range(0, 3))},
                           9'($urandom_range(0, 3)),
                           {12'($urandom_range(0, 7)), 10'($urandom_range(0, 3)), 2'b00,
                            8'($urandom) | (($urandom_range(0, 5) != 0) ? 8'h41 : 8'h00)},
                           ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 19) == 0)
                set_flush(1'($urandom), {10'($urandom_range(1, 3)), 10'($urandom_range(0, 3))},
                          1'($urandom), 9'($urandom_range(0, 3)));
            step();
        end

        // Asynchronous reset with a lookup in flight.
        refill(20'h40000, 9'd1, {22'h00400, 2'b00, 8'hCF}, 1'b0);
        lkp_valid = 1'b1; lkp_vaddr = 32'h4000_0000; lkp_asid = 9'd1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, resp_valid}, 64'd0);
        check("async_rst_miss",  {32'd0, miss_cnt},   64'd0);
        @(posedge clk);
        #1;
        check("rst_no_resp", {63'd0, resp_valid}, 64'd0);
        lkp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        lookup(32'h4000_0000, 9'd1, 2'b01, 1'b1, 1'b0);
        check("post_rst_miss", {63'd0, resp_hit}, 64'd0);
        lookup(32'h1230_0ABC, 9'd3, 2'b00, 1'b1, 1'b0);
        check("post_rst_miss2", {63'd0, resp_hit}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
